// File: rtl/dcache_snoop_responder.sv
// DCache snoop responder: AC snoop request -> arbitrated line read -> CD burst.
// Define DCACHE_SNOOP_SKID_EN for a one-entry request buffer (accept while busy).
`ifndef DCACHE_BANK
`define DCACHE_BANK 8
`endif
`ifndef PADDR_SIZE
`define PADDR_SIZE 32
`endif
`ifndef CORE_WIDTH
`define CORE_WIDTH 1
`endif
`ifndef XLEN
`define XLEN 32
`endif

module dcache_snoop_responder #(
  parameter int BEATS     = `DCACHE_BANK,
  parameter int MAX_RETRY = 3,
  parameter int RETRY_GAP = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ac_valid,
  output logic                       ac_ready,
  input  logic [`PADDR_SIZE-1:0]     ac_addr,
  input  logic [7:0]                 ac_len,
  input  logic [`CORE_WIDTH+1:0]     ac_user,
  output logic                       cd_valid,
  input  logic                       cd_ready,
  output logic [`XLEN-1:0]           cd_data,
  output logic                       cd_last,
  output logic [`CORE_WIDTH+1:0]     cd_user,
  output logic                       lr_req,
  input  logic                       lr_ready,
  output logic [`PADDR_SIZE-1:0]     lr_addr,
  input  logic                       lr_rvalid,
  input  logic                       lr_hit,
  input  logic [BEATS*`XLEN-1:0]     lr_data,
  output logic                       snoop_err
);

  localparam int XL = `XLEN;
  localparam int PA = `PADDR_SIZE;
  localparam int UW = `CORE_WIDTH + 2;
  localparam int WB = $clog2(BEATS);
  localparam int CW = WB + 1;
  localparam int OB = $clog2(XL / 8);
  localparam int LB = OB + WB;
  localparam int RB = $clog2(MAX_RETRY + 1);
  localparam int GB = (RETRY_GAP > 1) ? $clog2(RETRY_GAP) : 1;

  typedef enum logic [2:0] {
    IDLE, REQ, WAIT, STREAM, GAP
  } state_t;

  state_t               state;
  logic [PA-1:OB]       addr_q;
  logic [7:0]           len_q;
  logic [UW-1:0]        user_q;
  logic [RB-1:0]        retry_q;
  logic [GB-1:0]        gap_q;
  logic [BEATS*XL-1:0]  line_q;
  logic [WB-1:0]        word_q;
  logic [CW-1:0]        left_q;
  logic [CW-1:0]        bcnt;

  logic                 ac_hs;
  logic                 last_hs;
  logic                 nx_v;
  logic [PA-1:OB]       nx_addr;
  logic [7:0]           nx_len;
  logic [UW-1:0]        nx_user;
  logic                 unused;

  assign unused  = ^ac_addr[OB-1:0];
  assign ac_hs   = ac_valid & ac_ready;
  assign last_hs = (state == STREAM) & cd_valid & cd_ready & cd_last;
  assign lr_addr = {addr_q[PA-1:LB], {LB{1'b0}}};
  assign cd_data = line_q[int'(word_q)*XL +: XL];
  assign cd_user = user_q;

  // bursts longer than a line are clamped to one full (wrapped) line
  always_comb begin
    bcnt = CW'(BEATS);
    if (int'(len_q) < BEATS - 1)
      bcnt = CW'(len_q) + CW'(1);
  end

`ifdef DCACHE_SNOOP_SKID_EN
  logic           sk_v;
  logic [PA-1:OB] sk_addr;
  logic [7:0]     sk_len;
  logic [UW-1:0]  sk_user;

  assign ac_ready = ~sk_v | last_hs;
  assign nx_v     = sk_v | ac_hs;
  assign nx_addr  = sk_v ? sk_addr : ac_addr[PA-1:OB];
  assign nx_len   = sk_v ? sk_len : ac_len;
  assign nx_user  = sk_v ? sk_user : ac_user;

  always_ff @(posedge clk) begin
    if (rst) begin
      sk_v    <= 1'b0;
      sk_addr <= '0;
      sk_len  <= '0;
      sk_user <= '0;
    end else if (last_hs) begin
      sk_v <= sk_v & ac_hs;
      if (sk_v & ac_hs) begin
        sk_addr <= ac_addr[PA-1:OB];
        sk_len  <= ac_len;
        sk_user <= ac_user;
      end
    end else if (state != IDLE && ac_hs) begin
      sk_v    <= 1'b1;
      sk_addr <= ac_addr[PA-1:OB];
      sk_len  <= ac_len;
      sk_user <= ac_user;
    end
  end
`else
  assign ac_ready = (state == IDLE);
  assign nx_v     = 1'b0;
  assign nx_addr  = ac_addr[PA-1:OB];
  assign nx_len   = ac_len;
  assign nx_user  = ac_user;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      user_q    <= '0;
      retry_q   <= '0;
      gap_q     <= '0;
      word_q    <= '0;
      left_q    <= '0;
      cd_valid  <= 1'b0;
      cd_last   <= 1'b0;
      lr_req    <= 1'b0;
      snoop_err <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ac_hs) begin
            addr_q  <= ac_addr[PA-1:OB];
            len_q   <= ac_len;
            user_q  <= ac_user;
            retry_q <= '0;
            lr_req  <= 1'b1;
            state   <= REQ;
          end
        end
        REQ: begin
          if (lr_ready) begin
            lr_req <= 1'b0;
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (lr_rvalid) begin
            if (lr_hit || retry_q == RB'(MAX_RETRY)) begin
              line_q   <= lr_hit ? lr_data : '0;
              if (!lr_hit)
                snoop_err <= 1'b1;
              word_q   <= addr_q[LB-1:OB];
              left_q   <= bcnt;
              cd_last  <= (bcnt == CW'(1));
              cd_valid <= 1'b1;
              state    <= STREAM;
            end else begin
              retry_q <= retry_q + RB'(1);
              gap_q   <= '0;
              state   <= GAP;
            end
          end
        end
        GAP: begin
          if (gap_q == GB'(RETRY_GAP - 1)) begin
            lr_req <= 1'b1;
            state  <= REQ;
          end else begin
            gap_q <= gap_q + GB'(1);
          end
        end
        STREAM: begin
          if (last_hs) begin
            cd_valid <= 1'b0;
            cd_last  <= 1'b0;
            if (nx_v) begin
              addr_q  <= nx_addr;
              len_q   <= nx_len;
              user_q  <= nx_user;
              retry_q <= '0;
              lr_req  <= 1'b1;
              state   <= REQ;
            end else begin
              state <= IDLE;
            end
          end else if (cd_ready) begin
            word_q  <= word_q + WB'(1);
            left_q  <= left_q - CW'(1);
            cd_last <= (left_q == CW'(2));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_snoop_responder.sv
// Scoreboard bench for dcache_snoop_responder: directed snoops, line-read model,
// decoupled CD monitor.
`ifndef DCACHE_BANK
`define DCACHE_BANK 8
`endif
`ifndef PADDR_SIZE
`define PADDR_SIZE 32
`endif
`ifndef CORE_WIDTH
`define CORE_WIDTH 1
`endif
`ifndef XLEN
`define XLEN 32
`endif

module tb_dcache_snoop_responder;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ac_valid = 1'b0;
  logic         ac_ready;
  logic [31:0]  ac_addr = '0;
  logic [7:0]   ac_len = '0;
  logic [2:0]   ac_user = '0;
  logic         cd_valid;
  logic         cd_ready = 1'b1;
  logic [31:0]  cd_data;
  logic         cd_last;
  logic [2:0]   cd_user;
  logic         lr_req;
  logic         lr_ready = 1'b1;
  logic [31:0]  lr_addr;
  logic         lr_rvalid = 1'b0;
  logic         lr_hit = 1'b0;
  logic [255:0] lr_data;
  logic         snoop_err;

  dcache_snoop_responder dut (
    .clk(clk), .rst(rst),
    .ac_valid(ac_valid), .ac_ready(ac_ready), .ac_addr(ac_addr),
    .ac_len(ac_len), .ac_user(ac_user),
    .cd_valid(cd_valid), .cd_ready(cd_ready), .cd_data(cd_data),
    .cd_last(cd_last), .cd_user(cd_user),
    .lr_req(lr_req), .lr_ready(lr_ready), .lr_addr(lr_addr),
    .lr_rvalid(lr_rvalid), .lr_hit(lr_hit), .lr_data(lr_data),
    .snoop_err(snoop_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
    logic [2:0]  u;
  } beat_t;

  logic [31:0] wd [8] = '{
    32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h4444_0003,
    32'h5555_0004, 32'h6666_0005, 32'h7777_0006, 32'h8888_0007
  };

  beat_t       exp_q[$];
  bit          hit_q[$];
  int          gcyc[$];
  int          lcyc[$];
  int          checks = 0;
  int          fails = 0;
  int          cyc = 0;
  int          pops = 0;
  int          grants = 0;
  int          miss_cyc = 0;
  bit          last_miss = 1'b0;
  bit          grant_seen = 1'b0;
  bit          tgl = 1'b0;
  bit          stall_prev = 1'b0;
  logic [35:0] held = '0;
  logic [31:0] exp_line = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // line-read model: grant -> result one cycle later, hit pattern from hit_q
  initial begin
    for (int i = 0; i < 8; i++) lr_data[i*32 +: 32] = wd[i];
    forever begin
      @(negedge clk);
      lr_rvalid = 1'b0;
      if (grant_seen) begin
        grant_seen = 1'b0;
        lr_rvalid  = 1'b1;
        lr_hit     = (hit_q.size() != 0) ? hit_q.pop_front() : 1'b1;
        if (!lr_hit) begin
          last_miss = 1'b1;
          miss_cyc  = cyc;
        end
      end
      if (lr_req && lr_ready) begin
        grants++;
        gcyc.push_back(cyc);
        grant_seen = 1'b1;
        chk("lr_addr", 64'(lr_addr), 64'(exp_line));
        if (last_miss) begin
          chk("retry_gap", 64'(cyc - miss_cyc - 1), 64'd4);
          last_miss = 1'b0;
        end
      end
    end
  end

  // CD driver and monitor
  initial begin
    forever begin
      @(negedge clk);
      cd_ready = tgl ? ~cd_ready : 1'b1;
      if (stall_prev && cd_valid)
        chk("cd_stable", 64'({cd_data, cd_last, cd_user}), 64'(held));
      if (cd_valid && cd_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 64'({cd_data, cd_last, cd_user}), 64'hdead);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("beat", 64'({cd_data, cd_last, cd_user}), 64'({e.d, e.l, e.u}));
        end
        pops++;
        if (cd_last) lcyc.push_back(cyc);
      end
      stall_prev = cd_valid && !cd_ready;
      held = {cd_data, cd_last, cd_user};
    end
  end

  task automatic start_test(input logic [31:0] line);
    exp_line  = line;
    grants    = 0;
    last_miss = 1'b0;
    gcyc.delete();
    lcyc.delete();
  endtask

  task automatic expect_burst(input int start, input int n, input bit zero,
                              input logic [2:0] u);
    for (int k = 0; k < n; k++) begin
      beat_t b;
      b.d = zero ? 32'h0 : wd[(start + k) % 8];
      b.l = (k == n - 1);
      b.u = u;
      exp_q.push_back(b);
    end
  endtask

  task automatic send_ac(input logic [31:0] a, input logic [7:0] l,
                         input logic [2:0] u);
    bit hs;
    bit done;
    done     = 1'b0;
    ac_addr  = a;
    ac_len   = l;
    ac_user  = u;
    ac_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      hs = ac_ready;
      tick();
      done = hs;
    end
    ac_valid = 1'b0;
    if (!done) chk("ac_handshake_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_done();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      tick();
      done = (exp_q.size() == 0) && !cd_valid;
    end
    if (!done) chk("burst_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_valid();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      tick();
      done = cd_valid;
    end
    if (!done) chk("cd_valid_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int p0;
    repeat (3) tick();
    chk("rst_ac_ready", 64'(ac_ready), 64'd1);
    chk("rst_cd_valid", 64'(cd_valid), 64'd0);
    chk("rst_cd_last", 64'(cd_last), 64'd0);
    chk("rst_lr_req", 64'(lr_req), 64'd0);
    chk("rst_snoop_err", 64'(snoop_err), 64'd0);
    rst = 1'b0;
    tick();

    // aligned full line, grant held off for a few cycles
    start_test(32'h8000_0040);
    expect_burst(0, 8, 1'b0, 3'b110);
    lr_ready = 1'b0;
    send_ac(32'h8000_0040, 8'd7, 3'b110);
    repeat (3) tick();
    chk("lr_req_held", 64'(lr_req), 64'd1);
    lr_ready = 1'b1;
    wait_valid();
`ifdef DCACHE_SNOOP_SKID_EN
    chk("ac_ready_busy", 64'(ac_ready), 64'd1);
`else
    chk("ac_ready_busy", 64'(ac_ready), 64'd0);
`endif
    wait_done();
    chk("grants_full", 64'(grants), 64'd1);

    // wrapping burst under back-pressure
    start_test(32'h8000_0040);
    tgl = 1'b1;
    expect_burst(6, 4, 1'b0, 3'b010);
    send_ac(32'h8000_0058, 8'd3, 3'b010);
    wait_done();
    tgl = 1'b0;

    // single beat
    start_test(32'h8000_0040);
    expect_burst(3, 1, 1'b0, 3'b001);
    send_ac(32'h8000_004C, 8'd0, 3'b001);
    wait_done();
    chk("single_ac_ready", 64'(ac_ready), 64'd1);
    chk("single_cd_last", 64'(cd_last), 64'd0);

    // len beyond line size clamps to one wrapped line
    start_test(32'h8000_0040);
    expect_burst(2, 8, 1'b0, 3'b101);
    send_ac(32'h8000_0048, 8'd20, 3'b101);
    wait_done();

    // two misses then a hit
    start_test(32'h8000_0080);
    hit_q = '{1'b0, 1'b0, 1'b1};
    expect_burst(0, 8, 1'b0, 3'b011);
    send_ac(32'h8000_0080, 8'd7, 3'b011);
    wait_done();
    chk("grants_retry", 64'(grants), 64'd3);
    chk("retry_err", 64'(snoop_err), 64'd0);

    // retries exhausted -> zero data, sticky error
    start_test(32'h8000_0080);
    hit_q = '{1'b0, 1'b0, 1'b0, 1'b0};
    expect_burst(1, 3, 1'b1, 3'b100);
    send_ac(32'h8000_0084, 8'd2, 3'b100);
    wait_done();
    chk("grants_exhaust", 64'(grants), 64'd4);
    chk("exhaust_err", 64'(snoop_err), 64'd1);
    repeat (5) tick();
    chk("err_sticky", 64'(snoop_err), 64'd1);

    // reset while beat 2 of 8 is presented
    start_test(32'h8000_0040);
    expect_burst(0, 8, 1'b0, 3'b110);
    p0 = pops;
    send_ac(32'h8000_0040, 8'd7, 3'b110);
    for (int i = 0; i < 200 && pops != p0 + 1; i++) tick();
    chk("mid_beat2_valid", 64'(cd_valid), 64'd1);
    chk("mid_err_sticky", 64'(snoop_err), 64'd1);
    rst = 1'b1;
    tick();
    chk("mid_rst_cd_valid", 64'(cd_valid), 64'd0);
    chk("mid_rst_ac_ready", 64'(ac_ready), 64'd1);
    chk("mid_rst_err", 64'(snoop_err), 64'd0);
    rst = 1'b0;
    exp_q.delete();
    tick();
    start_test(32'h8000_0040);
    expect_burst(5, 2, 1'b0, 3'b111);
    send_ac(32'h8000_0054, 8'd1, 3'b111);
    wait_done();
    chk("post_rst_grants", 64'(grants), 64'd1);

`ifdef DCACHE_SNOOP_SKID_EN
    // second request buffered mid-burst
    start_test(32'h8000_0040);
    hit_q = '{1'b1, 1'b1};
    expect_burst(0, 8, 1'b0, 3'b001);
    expect_burst(4, 2, 1'b0, 3'b010);
    send_ac(32'h8000_0040, 8'd7, 3'b001);
    wait_valid();
    send_ac(32'h8000_0050, 8'd1, 3'b010);
    wait_done();
    chk("skid_grants", 64'(gcyc.size()), 64'd2);
    if (gcyc.size() == 2 && lcyc.size() >= 1)
      chk("skid_req_latency", 64'(gcyc[1]), 64'(lcyc[0] + 1));
`endif

    repeat (3) tick();
    chk("leftover_expected", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/dcache_snoop_responder.md
Name: dcache_snoop_responder

Overview:
- Sits inside the DCache on the slave side of NativeSnoopIO, directly downstream of the coherence snoop issuer.
- Accepts one snoop read request per AC handshake and reads the whole line from the DCache through an arbitrated line-read port. That port covers both the data array and the writeback/eviction buffer.
- Streams the requested words back on the CD channel as an AXI-R-like burst with a last flag and the echoed user ID.
- Retries when the line is transiently unavailable, and reports persistent misses.

Parameters:
- BEATS, `DCACHE_BANK: words per cache line; power of two.
- MAX_RETRY, 3: line-read misses tolerated before giving up.
- RETRY_GAP, 4: idle cycles between a miss and the next line-read request.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ac_valid  in  1  snoop request valid
- ac_ready  out  1  snoop request accepted
- ac_addr  in  `PADDR_SIZE  byte address of the first requested word
- ac_len  in  8  burst length minus 1 (AXI len)
- ac_user  in  `CORE_WIDTH+2  requester ID, echoed on cd_user
- cd_valid  out  1  data beat valid
- cd_ready  in  1  data beat accepted
- cd_data  out  `XLEN  data word
- cd_last  out  1  final beat of the burst
- cd_user  out  `CORE_WIDTH+2  echoed ac_user
- lr_req  out  1  line-read request to the DCache arbiter
- lr_ready  in  1  line-read grant
- lr_addr  out  `PADDR_SIZE  line-aligned address (word/byte offset bits zero)
- lr_rvalid  in  1  line-read result valid; one pulse per grant, any latency ≥1
- lr_hit  in  1  line found in the data array or the writeback buffer
- lr_data  in  BEATS*`XLEN  full line; word i at bits [i*`XLEN +: `XLEN]
- snoop_err  out  1  sticky: a request exhausted its retries

Behaviour:
- Clocking: single clock, clk; reset synchronous active-high, rst. All state is updated on posedge clk.
- Reset values: ac_ready=1, cd_valid=0, cd_last=0, lr_req=0, snoop_err=0, state=IDLE, counters=0. Reset mid-burst abandons the burst immediately: cd_valid is 0 on the cycle after rst.
- FSM states: IDLE, REQ, WAIT, STREAM, GAP.
- IDLE
  - ac_ready=1.
  - On ac_valid, latch addr, len, user; clear the retry count; go to REQ.
- REQ
  - lr_req=1 with lr_addr = latched line address.
  - Hold until lr_ready, then go to WAIT. lr_req drops the cycle after the grant.
- WAIT
  - On lr_rvalid & lr_hit: latch lr_data into the line buffer; go to STREAM.
  - On lr_rvalid & ~lr_hit, retry count < MAX_RETRY: increment the count; go to GAP.
  - On lr_rvalid & ~lr_hit, retry count == MAX_RETRY: zero-fill the buffer; set snoop_err; go to STREAM.
- GAP
  - Count RETRY_GAP cycles, then go to REQ.
- STREAM
  - cd_valid=1; cd_data = buffer[word]; cd_user = latched user.
  - Start word = ac_addr word-offset field.
  - Word index increments modulo BEATS: a burst wraps within the line. Example: BEATS=8, start word 6, len 3 gives words 6,7,0,1.
  - Beat count = ac_len+1, clamped to BEATS. ac_len ≥ BEATS-1 yields exactly BEATS beats.
  - cd_last=1 on the final beat.
  - Advance only on cd_valid & cd_ready. cd_data, cd_user and cd_last stay stable while cd_valid & ~cd_ready.
  - The last handshake returns to IDLE. ac_ready rises the following cycle (base build), so there is no back-to-back acceptance.
- Latency: AC handshake to lr_req is 1 cycle. lr_rvalid (hit) to the first cd_valid is 1 cycle.
- Outstanding requests: exactly one line read at a time. lr_rvalid outside WAIT is ignored.
- ac_ready is 0 in every state other than IDLE (base build).
- snoop_err clears only on rst.

Optional Feature:
- DCACHE_SNOOP_SKID_EN defined: adds a one-entry request buffer (addr, len, user).
  - ac_ready = ~buffer_full, in any state.
  - A request accepted while busy is held in the buffer.
  - On the final handshake of the current burst, the FSM goes directly to REQ with the buffered request. The buffer empties in that same cycle.
  - A new ac_valid in that same cycle is accepted into the freed entry.
  - In IDLE, a request bypasses the buffer.
- Undefined: no buffer; ac_ready is high only in IDLE, as above.

Test Plan:
- Aligned full burst: BEATS=8, ac_addr=0x8000_0040, len=7, lr_hit first try -> lr_addr=0x8000_0040; 8 beats of words 0..7; cd_last on beat 8; cd_user echoes ac_user=0b11_0.
- Wrapping burst with back-pressure: start word 6, len=3, cd_ready toggles 1/0 -> words 6,7,0,1 in order; data stable during stalls; cd_last only on word 1.
- Single beat: len=0, start word 3 -> one beat, word 3, cd_last=1; returns to IDLE, ac_ready=1 the next cycle.
- Retry then hit: lr_hit=0,0,1 -> exactly 3 lr_req grants, each preceded by RETRY_GAP=4 idle cycles after a miss; correct data; snoop_err=0.
- Exhausted retries: 4 misses -> zero-data burst of len+1 beats; snoop_err=1 and stays 1 until rst.
- Reset mid-stream on beat 2 of 8 -> cd_valid=0 next cycle; ac_ready=1; a new request completes normally. Under DCACHE_SNOOP_SKID_EN: a second ac accepted mid-burst gets lr_req in the cycle after the first burst's last handshake.
